hazard_scheduler: RTL and testbench
===================================

Name: hazard_scheduler

Overview:
- Pipeline hazard controller between ControlPath and DataPath of the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Keeps a shadow pipeline of in-flight destination registers in EX/MEM/WB.
- Decides per cycle whether ID advances, stalls, takes a bubble or is flushed.
- Produces registered forwarding selects and the Flags signals (we_bypass, we_stall, curr_rd).

Parameters:
REG_W, 5, register index width (32 architectural registers; x0 hard-wired zero)
FLUSH_CYCLES, 2, bubble cycles inserted after a taken branch/jump (1..7)

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
id_valid  input  1  ID holds a real instruction
id_rs1  input  REG_W  ID source 1 index
id_rs2  input  REG_W  ID source 2 index
id_rd  input  REG_W  ID destination index
id_reg_write  input  1  ID instruction writes rd
id_is_load  input  1  ID instruction is a load
ex_branch_taken  input  1  EX resolved taken branch/jump this cycle
mem_busy  input  1  data memory not ready; freeze whole pipe
stall_if_id  output  1  hold PC and IF/ID register
bubble_ex  output  1  load NOP into ID/EX instead of ID instruction
flush_if_id  output  1  invalidate IF/ID register
freeze  output  1  hold every pipeline register
fwd_a  output  2  EX operand A source: 0 regfile, 1 EX/MEM, 2 MEM/WB
fwd_b  output  2  EX operand B source, same encoding
we_bypass  output  1  fwd_a != 0 or fwd_b != 0
we_stall  output  1  equals stall_if_id
curr_rd  output  REG_W  rd of EX shadow slot (0 if slot invalid)

Behaviour:
- Reset (rst=1 at posedge): state=RUN, all shadow slots invalid with rd=0, flush counter=0, fwd_a=fwd_b=0. Combinational outputs follow from this state, so stall_if_id=bubble_ex=flush_if_id=freeze=we_*=0 and curr_rd=0. Reset mid-stall or mid-flush aborts it.
- Shadow slot = {valid, rd, reg_write, is_load}. On advance: EX<-ID-or-bubble, MEM<-EX, WB<-MEM. On freeze: no shift.
- Match(src, slot) = slot.valid & slot.reg_write & slot.rd==src & src!=0.
- Load-use hazard = id_valid & (Match(rs1,EX) | Match(rs2,EX)) & EX.is_load.
- States: RUN, LOAD_STALL, MEM_WAIT, FLUSH. Priority each cycle: mem_busy > ex_branch_taken > load-use.
- RUN:
  - mem_busy -> freeze=1, go MEM_WAIT.
  - else ex_branch_taken -> flush_if_id=1, bubble_ex=1, counter<=FLUSH_CYCLES-1, go FLUSH (stay RUN if FLUSH_CYCLES=1).
  - else load-use -> stall_if_id=1, bubble_ex=1, go LOAD_STALL.
  - else advance normally.
- LOAD_STALL: exactly one cycle. Re-evaluate as RUN without the load-use term (the load is now in MEM), so ID advances with fwd=2. mem_busy still has priority.
- MEM_WAIT: freeze=1 while mem_busy; when mem_busy=0, return to RUN the same cycle and evaluate as RUN. A branch arriving during a freeze is held by EX and seen on exit.
- FLUSH: flush_if_id=1, bubble_ex=1 each cycle; counter decrements; counter==0 -> RUN. ex_branch_taken during FLUSH is ignored (EX holds a bubble). mem_busy freezes the counter.
- Forwarding is registered on each advance for the instruction entering EX, evaluated against pre-shift slots:
  - fwd=1 if Match(src, EX) & !EX.is_load;
  - else fwd=2 if Match(src, MEM);
  - else 0.
  - EX beats MEM when both match. Bubble or freeze: fwd holds on freeze and is cleared to 0 on bubble.
- we_bypass and curr_rd are derived from the registered state; no combinational path from id_* to fwd_*.

Test Plan:
- Reset then add x3,x1,x2 followed by sub x4,x3,x5 -> in the sub's EX cycle fwd_a=1, fwd_b=0, we_bypass=1, curr_rd=4.
- lw x6,0(x1) then add x7,x6,x6 -> one cycle stall_if_id=1, bubble_ex=1, we_stall=1; the add enters EX with fwd_a=fwd_b=2.
- Writer to x0 followed by a reader of x0 -> fwd_a=0, no stall.
- ex_branch_taken=1 with FLUSH_CYCLES=2 -> flush_if_id=1 for exactly 2 cycles, bubble_ex=1 for 2 cycles, then RUN.
- mem_busy high for 3 cycles coincident with a load-use hazard -> freeze=1 for 3 cycles, slots unchanged; on the release cycle the load-use stall asserts; fwd values held.
- rst asserted during the FLUSH counter=1 cycle -> next cycle all outputs 0, state RUN; the following add/sub pair forwards correctly.

Source files
------------

// File: rtl/hazard_scheduler_if.sv
// ID-stage / control bundle between ControlPath, DataPath and the hazard unit.
// master drives the decoded ID fields, slave returns stall/flush/forward controls.
interface hazard_scheduler_if #(
    parameter int REG_W = 5
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_is_load;
    logic             ex_branch_taken;
    logic             mem_busy;
    logic             stall_if_id;
    logic             bubble_ex;
    logic             flush_if_id;
    logic             freeze;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             we_bypass;
    logic             we_stall;
    logic [REG_W-1:0] curr_rd;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_is_load,
        output ex_branch_taken, mem_busy,
        input  stall_if_id, bubble_ex, flush_if_id, freeze,
        input  fwd_a, fwd_b, we_bypass, we_stall, curr_rd
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_is_load,
        input  ex_branch_taken, mem_busy,
        output stall_if_id, bubble_ex, flush_if_id, freeze,
        output fwd_a, fwd_b, we_bypass, we_stall, curr_rd
    );
endinterface

// File: rtl/hazard_scheduler.sv
// Hazard controller for the 5-stage RV32I pipe: tracks in-flight rd in EX/MEM,
// decides stall/bubble/flush/freeze and registers the EX forwarding selects.
module hazard_scheduler #(
    parameter int REG_W        = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                clk,
    input logic                rst,
    hazard_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, FLUSH} state_t;
    localparam int CW = 3;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // EX shadow slot
    logic             ex_v_q, ex_rw_q, ex_ld_q;
    logic [REG_W-1:0] ex_rd_q;
    // MEM shadow slot; the WB slot is not tracked since nothing forwards from it
    logic             mem_v_q, mem_rw_q;
    logic [REG_W-1:0] mem_rd_q;

    logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic             stall, bubble, flush, frz, load_use;
    logic             ex_a, ex_b, mem_a, mem_b;

    function automatic logic hit(input logic [REG_W-1:0] src,
                                 input logic v, input logic rw,
                                 input logic [REG_W-1:0] rd);
        return v & rw & (rd == src) & (src != '0);
    endfunction

    // Hazard decision and forwarding selects for the instruction in ID
    always_comb begin
        ex_a     = hit(bus.id_rs1, ex_v_q, ex_rw_q, ex_rd_q);
        ex_b     = hit(bus.id_rs2, ex_v_q, ex_rw_q, ex_rd_q);
        mem_a    = hit(bus.id_rs1, mem_v_q, mem_rw_q, mem_rd_q);
        mem_b    = hit(bus.id_rs2, mem_v_q, mem_rw_q, mem_rd_q);
        fwd_a_d  = (ex_a & ~ex_ld_q) ? 2'd1 : (mem_a ? 2'd2 : 2'd0);
        fwd_b_d  = (ex_b & ~ex_ld_q) ? 2'd1 : (mem_b ? 2'd2 : 2'd0);
        load_use = bus.id_valid & ex_ld_q & (ex_a | ex_b)
                 & (state_q != LOAD_STALL);
        stall    = 1'b0;
        bubble   = 1'b0;
        flush    = 1'b0;
        frz      = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (bus.mem_busy) begin
            frz     = 1'b1;
            state_d = (state_q == FLUSH) ? FLUSH : MEM_WAIT;
        end else if (state_q == FLUSH) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? RUN : FLUSH;
        end else if (bus.ex_branch_taken) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            cnt_d   = CW'(FLUSH_CYCLES - 1);
            state_d = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
        end else if (load_use) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = LOAD_STALL;
        end else begin
            state_d = RUN;
        end
    end

    // State, shadow pipeline shift and registered forwarding selects
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            ex_v_q   <= 1'b0;
            ex_rw_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            ex_rd_q  <= '0;
            mem_v_q  <= 1'b0;
            mem_rw_q <= 1'b0;
            mem_rd_q <= '0;
            fwd_a_q  <= 2'd0;
            fwd_b_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!frz) begin
                mem_v_q  <= ex_v_q;
                mem_rw_q <= ex_rw_q;
                mem_rd_q <= ex_rd_q;
                if (bubble) begin
                    ex_v_q  <= 1'b0;
                    ex_rw_q <= 1'b0;
                    ex_ld_q <= 1'b0;
                    ex_rd_q <= '0;
                    fwd_a_q <= 2'd0;
                    fwd_b_q <= 2'd0;
                end else begin
                    ex_v_q  <= bus.id_valid;
                    ex_rw_q <= bus.id_reg_write;
                    ex_ld_q <= bus.id_is_load;
                    ex_rd_q <= bus.id_rd;
                    fwd_a_q <= fwd_a_d;
                    fwd_b_q <= fwd_b_d;
                end
            end
        end
    end

    assign bus.stall_if_id = stall;
    assign bus.bubble_ex   = bubble;
    assign bus.flush_if_id = flush;
    assign bus.freeze      = frz;
    assign bus.fwd_a       = fwd_a_q;
    assign bus.fwd_b       = fwd_b_q;
    assign bus.we_bypass   = (fwd_a_q != 2'd0) | (fwd_b_q != 2'd0);
    assign bus.we_stall    = stall;
    assign bus.curr_rd     = ex_v_q ? ex_rd_q : '0;
endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed pipeline scenarios then random traffic,
// every cycle compared against an instruction-level reference model.
module tb_hazard_scheduler;
    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scheduler_if #(.REG_W(5)) bus ();

    hazard_scheduler #(.REG_W(5), .FLUSH_CYCLES(FC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       ld;
    } ins_t;

    ins_t     ex_i, mem_i;
    int       flush_left;
    bit       after_ls;
    bit [1:0] mfa, mfb;
    int       errors = 0;
    int       checks = 0;
    bit       o_stall, o_bub, o_flush, o_frz;

    function automatic bit writes(ins_t s, bit [4:0] r);
        return s.v && s.rw && r != 0 && s.rd == r;
    endfunction

    function automatic bit [1:0] src_of(bit [4:0] r);
        if (writes(ex_i, r) && !ex_i.ld) return 2'd1;
        if (writes(mem_i, r)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        ex_i = '0; mem_i = '0;
        flush_left = 0; after_ls = 0;
        mfa = 0; mfb = 0;
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit v, bit [4:0] a, bit [4:0] b, bit [4:0] d,
                        bit rw, bit ld, bit br, bit mb, bit r);
        bit hz, es, ef, eb;
        ins_t nx;
        @(negedge clk);
        rst = r;
        bus.id_valid = v; bus.id_rs1 = a; bus.id_rs2 = b; bus.id_rd = d;
        bus.id_reg_write = rw; bus.id_is_load = ld;
        bus.ex_branch_taken = br; bus.mem_busy = mb;
        #1;
        hz = v && !after_ls && ex_i.ld && (writes(ex_i, a) || writes(ex_i, b));
        ef = !mb && (flush_left > 0 || br);
        es = !mb && !ef && hz;
        eb = ef || es;
        chk("stall_if_id", bus.stall_if_id, es);
        chk("bubble_ex", bus.bubble_ex, eb);
        chk("flush_if_id", bus.flush_if_id, ef);
        chk("freeze", bus.freeze, mb);
        chk("we_stall", bus.we_stall, es);
        chk("fwd_a", bus.fwd_a, mfa);
        chk("fwd_b", bus.fwd_b, mfb);
        chk("we_bypass", bus.we_bypass, (mfa != 0 || mfb != 0));
        chk("curr_rd", bus.curr_rd, ex_i.v ? ex_i.rd : 5'd0);
        o_stall = bus.stall_if_id; o_bub = bus.bubble_ex;
        o_flush = bus.flush_if_id; o_frz = bus.freeze;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (!mb) begin
            nx = eb ? ins_t'('0) : ins_t'({v, d, rw, ld});
            mfa = eb ? 2'd0 : src_of(a);
            mfb = eb ? 2'd0 : src_of(b);
            mem_i = ex_i;
            ex_i = nx;
            after_ls = es;
            if (flush_left > 0) flush_left--;
            else if (br) flush_left = FC - 1;
        end
    endtask

    task automatic idle(bit br, bit mb, bit r);
        step(0, 0, 0, 0, 0, 0, br, mb, r);
    endtask

    initial begin
        int n;
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_reg_write = 0; bus.id_is_load = 0;
        bus.ex_branch_taken = 0; bus.mem_busy = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // add x3,x1,x2 ; sub x4,x3,x5
        step(1, 1, 2, 3, 1, 0, 0, 0, 0);
        step(1, 3, 5, 4, 1, 0, 0, 0, 0);
        #2;
        chk("t1_fwd_a", bus.fwd_a, 2'd1);
        chk("t1_fwd_b", bus.fwd_b, 2'd0);
        chk("t1_bypass", bus.we_bypass, 1'b1);
        chk("t1_curr_rd", bus.curr_rd, 5'd4);

        // lw x6 ; add x7,x6,x6
        step(1, 1, 0, 6, 1, 1, 0, 0, 0);
        step(1, 6, 6, 7, 1, 0, 0, 0, 0);
        chk("t2_stall", o_stall, 1'b1);
        chk("t2_bubble", o_bub, 1'b1);
        step(1, 6, 6, 7, 1, 0, 0, 0, 0);
        chk("t2_no_stall", o_stall, 1'b0);
        #2;
        chk("t2_fwd_a", bus.fwd_a, 2'd2);
        chk("t2_fwd_b", bus.fwd_b, 2'd2);

        // lw x0 ; reader of x0
        step(1, 1, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 8, 1, 0, 0, 0, 0);
        chk("t3_no_stall", o_stall, 1'b0);
        #2;
        chk("t3_fwd_a", bus.fwd_a, 2'd0);

        // taken branch, two flush cycles
        n = 0;
        idle(1, 0, 0); n += o_flush;
        idle(0, 0, 0); n += o_flush;
        idle(0, 0, 0); n += o_flush;
        chk("t4_flush_cycles", 8'(n), 8'd2);

        // load-use held under a 3-cycle memory freeze
        step(1, 2, 0, 9, 1, 1, 0, 0, 0);
        n = 0;
        repeat (3) begin
            step(1, 9, 1, 10, 1, 0, 0, 1, 0);
            n += o_frz;
        end
        chk("t5_freeze_cycles", 8'(n), 8'd3);
        step(1, 9, 1, 10, 1, 0, 0, 0, 0);
        chk("t5_release_stall", o_stall, 1'b1);
        step(1, 9, 1, 10, 1, 0, 0, 0, 0);

        // reset in the middle of a flush
        idle(1, 0, 0);
        idle(0, 0, 1);
        idle(0, 0, 0);
        chk("t6_flush_cleared", o_flush, 1'b0);
        chk("t6_bubble_cleared", o_bub, 1'b0);
        step(1, 1, 2, 3, 1, 0, 0, 0, 0);
        step(1, 3, 5, 4, 1, 0, 0, 0, 0);
        #2;
        chk("t6_fwd_a", bus.fwd_a, 2'd1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 49) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
